// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: data-memory access controller between the MEM stage and a
// synchronous req/ack data memory. Registers one load/store, replicates
// store data across byte lanes and aligns/extends load data.
// Optional feature: define DM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (adds the dm_err_o port).
module dm_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              byte_i,
    input  logic              word_i,
    input  logic              uns_i,
    input  logic [3:0]        mask_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
`ifdef DM_MISALIGN_TRAP_EN
    output logic              dm_err_o,
`endif
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_be_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;

    state_e              state_q, state_d;
    logic                issue;      // launch a memory transaction this cycle
    logic                ack_take;   // memory completed the outstanding access
    logic                trap;       // misaligned request short-circuits to DONE
    logic                req;

    logic [ADDR_W-3:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [3:0]          mem_be_q;
    logic                mem_rd_q, mem_wr_q;
    logic                byte_q, word_q, uns_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic                err_q;

    logic [DATA_W-1:0]   wdata_rep;
    logic [DATA_W-1:0]   load_data;
    logic [7:0]          fld8;
    logic [15:0]         fld16;
    logic                misalign;

    assign req = cpu_rd_i | cpu_wr_i;

`ifdef DM_MISALIGN_TRAP_EN
    // Half needs 2-byte alignment, word needs 4-byte alignment; bytes never trap
    always_comb begin
        misalign = 1'b0;
        if (!byte_i) begin
            if (word_i) misalign = cpu_addr_i[0];
            else        misalign = |cpu_addr_i[1:0];
        end
    end
    assign dm_err_o = err_q;
`else
    // Low address bits only matter to the mask generator upstream
    logic unused_addr_lo;
    assign unused_addr_lo = ^cpu_addr_i[1:0];
    assign misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state, stall and transaction control
    always_comb begin
        state_d     = state_q;
        cpu_stall_o = 1'b0;
        issue       = 1'b0;
        ack_take    = 1'b0;
        trap        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cpu_stall_o = 1'b1;
                    if (misalign) begin
                        trap    = 1'b1;
                        state_d = DONE;
                    end else begin
                        issue   = 1'b1;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                cpu_stall_o = 1'b1;
                if (mem_ack_i) begin
                    ack_take = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Store data replicated so every enabled lane sees the right bytes
    always_comb begin
        wdata_rep = cpu_wdata_i;
        if (byte_i)      wdata_rep = {4{cpu_wdata_i[7:0]}};
        else if (word_i) wdata_rep = {2{cpu_wdata_i[15:0]}};
    end

    // Load lane select (big-endian: mask bit3 is bits 31:24) and extension
    always_comb begin
        fld8  = mem_rdata_i[7:0];
        fld16 = mem_rdata_i[15:0];
        case (mem_be_q)
            4'b1000: fld8 = mem_rdata_i[31:24];
            4'b0100: fld8 = mem_rdata_i[23:16];
            4'b0010: fld8 = mem_rdata_i[15:8];
            default: fld8 = mem_rdata_i[7:0];
        endcase
        if (mem_be_q == 4'b1100) fld16 = mem_rdata_i[31:16];
        if (byte_q)      load_data = {{24{~uns_q & fld8[7]}}, fld8};
        else if (word_q) load_data = {{16{~uns_q & fld16[15]}}, fld16};
        else             load_data = mem_rdata_i;
    end

    // Request latch, memory strobes and load result register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            byte_q      <= 1'b0;
            word_q      <= 1'b0;
            uns_q       <= 1'b0;
            cpu_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= trap;
            if (issue) begin
                mem_addr_q  <= cpu_addr_i[ADDR_W-1:2];
                mem_wdata_q <= wdata_rep;
                mem_be_q    <= mask_i;
                mem_wr_q    <= cpu_wr_i;
                mem_rd_q    <= ~cpu_wr_i;   // write wins when both are raised
                byte_q      <= byte_i;
                word_q      <= word_i;
                uns_q       <= uns_i;
            end else if (ack_take) begin
                mem_rd_q <= 1'b0;
                mem_wr_q <= 1'b0;
                if (mem_rd_q) cpu_rdata_q <= load_data;
            end
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_wr_o    = mem_wr_q;
    assign cpu_rdata_o = cpu_rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: expected load results are queued when a
// request is driven and compared in the cycle the controller releases the stall.
module tb_dm_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cpu_rd_i, cpu_wr_i, byte_i, word_i, uns_i, mem_ack_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i, mem_rdata_i, cpu_rdata_o, mem_wdata_o;
    logic [3:0]  mask_i, mem_be_o;
    logic [29:0] mem_addr_o;
    logic        cpu_stall_o, mem_rd_o, mem_wr_o;
`ifdef DM_MISALIGN_TRAP_EN
    logic        dm_err_o;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] model_rdata = 32'h0;

    always #5 clk_i = ~clk_i;

    dm_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .byte_i(byte_i), .word_i(word_i),
        .uns_i(uns_i), .mask_i(mask_i), .cpu_rdata_o(cpu_rdata_o),
        .cpu_stall_o(cpu_stall_o),
`ifdef DM_MISALIGN_TRAP_EN
        .dm_err_o(dm_err_o),
`endif
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference load alignment: shift the addressed lane down, then extend
    function automatic logic [31:0] exp_load(input logic [3:0] m, input logic b,
                                             input logic h, input logic u,
                                             input logic [31:0] d);
        int          off;
        int          w;
        logic [31:0] f;
        if (b) begin
            off = m[3] ? 0 : m[2] ? 1 : m[1] ? 2 : 3;
            f   = (d >> (8 * (3 - off))) & 32'hFF;
            w   = 8;
        end else if (h) begin
            f = m[3] ? (d >> 16) : (d & 32'hFFFF);
            w = 16;
        end else begin
            return d;
        end
        if (!u && f[w-1]) f = f | (32'hFFFF_FFFF << w);
        return f;
    endfunction

    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic b, input logic h, input logic u,
                          input logic [3:0] m, input logic [31:0] rdat, input int dly);
        logic [31:0] exp_wd;
        int          n;
        cpu_rd_i = rd; cpu_wr_i = wr; cpu_addr_i = addr; cpu_wdata_i = wd;
        byte_i = b; word_i = h; uns_i = u; mask_i = m;
        #1;
        chk({tag, ".stall0"}, cpu_stall_o, 1);
        if (!wr) model_rdata = exp_load(m, b, h, u, rdat);
        sb_q.push_back(model_rdata);
        exp_wd = b ? wd[7:0] * 32'h0101_0101 : h ? wd[15:0] * 32'h0001_0001 : wd;
        tick();
        chk({tag, ".wr"},    mem_wr_o, wr);
        chk({tag, ".rd"},    mem_rd_o, rd & ~wr);
        chk({tag, ".addr"},  mem_addr_o, addr >> 2);
        chk({tag, ".be"},    mem_be_o, m);
        chk({tag, ".wdata"}, mem_wdata_o, exp_wd);
        repeat (dly) tick();
        if (dly > 0) chk({tag, ".hold"}, mem_rd_o | mem_wr_o, 1);
        mem_ack_i = 1'b1; mem_rdata_i = rdat;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = $urandom;
        n = 0;
        while (cpu_stall_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".lat"},   n, 0);
        chk({tag, ".stall"}, cpu_stall_o, 0);
        chk({tag, ".rdata"}, cpu_rdata_o, sb_q.pop_front());
        chk({tag, ".strb"},  mem_rd_o | mem_wr_o, 0);
`ifdef DM_MISALIGN_TRAP_EN
        chk({tag, ".err"},   dm_err_o, 0);
`endif
        cpu_rd_i = 1'b0; cpu_wr_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_n_i = 1'b0; cpu_rd_i = 0; cpu_wr_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
        byte_i = 0; word_i = 0; uns_i = 0; mask_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
        repeat (3) tick();
        chk("rst.rdata", cpu_rdata_o, 0);
        chk("rst.strb",  {mem_rd_o, mem_wr_o}, 0);
        chk("rst.addr",  mem_addr_o, 0);
        chk("rst.wdata", mem_wdata_o, 0);
        chk("rst.be",    mem_be_o, 0);
        chk("rst.stall", cpu_stall_o, 0);
`ifdef DM_MISALIGN_TRAP_EN
        chk("rst.err",   dm_err_o, 0);
`endif
        rst_n_i = 1'b1;
        tick();

        //     tag    rd wr addr          wdata         b  h  u  mask     mem_rdata     dly
        access("stb",  0, 1, 32'h102,      32'h0000_00A5, 1, 0, 0, 4'b0010, 32'h0,        2);
        access("ldsb", 1, 0, 32'h0,        32'h0,        1, 0, 0, 4'b1000, 32'h8012_3456, 0);
        access("ldub", 1, 0, 32'h0,        32'h0,        1, 0, 1, 4'b1000, 32'h8012_3456, 0);
        access("ldsh", 1, 0, 32'h2,        32'h0,        0, 1, 0, 4'b0011, 32'h1234_F00D, 1);
        access("ldhh", 1, 0, 32'h4,        32'h0,        0, 1, 0, 4'b1100, 32'h7ABC_0000, 0);
        access("ldb2", 1, 0, 32'h9,        32'h0,        1, 0, 0, 4'b0100, 32'h11C3_2233, 3);
        access("ldb3", 1, 0, 32'hB,        32'h0,        1, 0, 1, 4'b0001, 32'h0000_00F7, 0);
        access("ldw",  1, 0, 32'hFFFF_FFFC, 32'h0,       0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 0);
        access("sth",  0, 1, 32'h20,       32'h1234_5678, 0, 1, 0, 4'b1100, 32'h0,        0);
        access("stw",  0, 1, 32'h24,       32'hCAFE_F00D, 0, 0, 0, 4'b1111, 32'h0,        1);
        access("rdwr", 1, 1, 32'h30,       32'h0000_0042, 1, 0, 0, 4'b1000, 32'hFFFF_FFFF, 0);

        // Stray ack while idle must not disturb anything
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_5555;
        tick();
        mem_ack_i = 1'b0;
        chk("stray.rdata", cpu_rdata_o, model_rdata);
        chk("stray.strb",  {mem_rd_o, mem_wr_o}, 0);
        chk("stray.stall", cpu_stall_o, 0);

        // Reset while waiting for ack, then a late ack after release
        cpu_rd_i = 1; cpu_addr_i = 32'h40; byte_i = 0; word_i = 0; mask_i = 4'b1111;
        tick();
        chk("rbus.rd", mem_rd_o, 1);
        rst_n_i = 1'b0; cpu_rd_i = 0;
        tick();
        rst_n_i = 1'b1;
        chk("rbus.strb",  {mem_rd_o, mem_wr_o}, 0);
        chk("rbus.rdata", cpu_rdata_o, 0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1357_9BDF;
        tick();
        mem_ack_i = 1'b0;
        chk("late.strb",  {mem_rd_o, mem_wr_o}, 0);
        chk("late.rdata", cpu_rdata_o, 0);
        chk("late.stall", cpu_stall_o, 0);
        tick();
        chk("late.rdata2", cpu_rdata_o, 0);
        model_rdata = 32'h0;

`ifdef DM_MISALIGN_TRAP_EN
        // Misaligned half load traps straight to DONE without a strobe
        cpu_rd_i = 1; cpu_addr_i = 32'h3; byte_i = 0; word_i = 1; uns_i = 0; mask_i = 4'b0011;
        #1;
        chk("mis.stall0", cpu_stall_o, 1);
        tick();
        chk("mis.err",   dm_err_o, 1);
        chk("mis.stall", cpu_stall_o, 0);
        chk("mis.strb",  {mem_rd_o, mem_wr_o}, 0);
        chk("mis.rdata", cpu_rdata_o, model_rdata);
        cpu_rd_i = 0;
        tick();
        chk("mis.err1",  dm_err_o, 0);
        chk("mis.strb1", {mem_rd_o, mem_wr_o}, 0);
`else
        access("mish", 1, 0, 32'h3, 32'h0, 0, 1, 0, 4'b0011, 32'h0000_8001, 0);
`endif

        access("post", 1, 0, 32'h50, 32'h0, 1, 0, 0, 4'b0010, 32'h0000_9900, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Data-memory access controller sitting between the DLX core's MEM stage and the synchronous data memory, directly downstream of the byte-lane mask generator. It registers one load/store request, drives a req/ack memory transaction using the supplied 4-bit big-endian lane mask, and stalls the core until the access completes. For stores it replicates byte/halfword data across lanes. For loads it extracts the addressed lane(s) and sign- or zero-extends them into a registered 32-bit result.

## Interface
- `ADDR_W`, 32: CPU byte-address width.
- `DATA_W`, 32: data width; fixed at 32 because lane logic assumes 4 byte lanes.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cpu_rd` in 1: load request, level, held while `cpu_stall`=1.
- `cpu_wr` in 1: store request, level, held while `cpu_stall`=1.
- `cpu_addr` in ADDR_W: byte address.
- `cpu_wdata` in 32: store data, right-justified.
- `byte` in 1: byte access.
- `word` in 1: 16-bit access; ignored when `byte`=1.
- `uns` in 1: load is zero-extended when 1, sign-extended when 0.
- `mask` in 4: lane mask from the mask generator; bit3 = bits 31:24 = address offset 0.
- `cpu_rdata` out 32: aligned load result, registered.
- `cpu_stall` out 1: core must hold its request and inputs.
- `dm_err` out 1: misaligned access flag; exists only with `DM_MISALIGN_TRAP_EN`.
- `mem_addr` out ADDR_W-2: word address.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables, equal to the latched `mask`.
- `mem_rd` / `mem_wr` out 1: memory strobes.
- `mem_ack` in 1: one-cycle completion pulse from memory.
- `mem_rdata` in 32: read data, valid in the `mem_ack` cycle.

## Operation
- States: IDLE, BUS, DONE. Reset state is IDLE.
- IDLE:
  - If `cpu_wr` or `cpu_rd` is high, latch `cpu_addr[ADDR_W-1:2]`, `mask`, `byte`, `word`, `uns`, and the type; go to BUS.
  - When both `cpu_wr` and `cpu_rd` are high, the write wins and the read is dropped.
- BUS:
  - `mem_rd` or `mem_wr` is held high with stable address, data and enables until `mem_ack`.
  - On `mem_ack`: for a load, register the aligned result into `cpu_rdata`; go to DONE.
- DONE: `cpu_stall`=0 for exactly one cycle so the core advances; return to IDLE. Requests present in DONE are not sampled.
- Store alignment:
  - byte: `mem_wdata` = {4{wdata[7:0]}}.
  - half: `mem_wdata` = {2{wdata[15:0]}}.
  - word: `mem_wdata` = wdata.
- Load extraction, by latched mask:
  - Byte: 1000→[31:24], 0100→[23:16], 0010→[15:8], 0001→[7:0]. Extend 8 bits to 32.
  - Half: 1100→[31:16], 0011→[15:0]. Extend 16 bits to 32.
  - Word (1111): pass through.
  - Extension uses the MSB of the extracted field when `uns`=0, zeros when `uns`=1.
- `cpu_rdata` holds its value except on a load ack. Stores leave it unchanged.
- `mem_ack` outside BUS is ignored.
- Reset mid-operation: at the first `rst_n`=0 edge, go to IDLE, strobes low, `cpu_rdata`=0. A late `mem_ack` after reset is ignored.

## Timing
- Reset values: `cpu_rdata`=0, `mem_rd`=`mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0, `dm_err`=0, state IDLE.
- `cpu_stall` is combinational: 1 in IDLE with a request present, 1 in BUS, 0 in DONE, 0 in IDLE with no request.
- Memory outputs are registered and appear the cycle after the request is sampled.
- Latency, request cycle = 0:
  - Strobes rise at cycle 1.
  - If ack arrives at cycle 1: DONE and `cpu_rdata` valid at cycle 2, `cpu_stall` low at cycle 2.
  - Each ack-wait cycle adds one cycle.
- Back-to-back: the next request is sampled in the IDLE cycle after DONE, so the minimum spacing is 3 cycles per access.
- Strobes fall in the cycle after `mem_ack`.

## Configuration
- `DM_MISALIGN_TRAP_EN` defined:
  - In IDLE, a request is misaligned when it is a half access with `cpu_addr[0]`=1, or a word access with `cpu_addr[1:0]`≠00.
  - A misaligned request goes directly to DONE and issues no memory strobe.
  - `dm_err` pulses high for the DONE cycle; `cpu_rdata` is unchanged.
- Undefined: `dm_err` port is absent. Misaligned requests are issued as-is with the supplied mask, and no check logic is present.

## Test plan
- Store byte: `cpu_wr`=1, addr=0x102, `byte`=1, wdata=0x000000A5, mask=0010 → cycle 1: `mem_addr`=0x40, `mem_be`=0010, `mem_wdata`=0xA5A5A5A5; ack at cycle 3 → stall low at cycle 4.
- Signed byte load: addr=0x0, mask=1000, `uns`=0, `mem_rdata`=0x80123456 → `cpu_rdata`=0xFFFFFF80. Repeat with `uns`=1 → 0x00000080.
- Half load: mask=0011, `uns`=0, `mem_rdata`=0x1234F00D → `cpu_rdata`=0xFFFFF00D.
- Simultaneous `cpu_rd`=`cpu_wr`=1 → only `mem_wr` is asserted; `cpu_rdata` is unchanged.
- Reset asserted in BUS with ack pending, then ack pulsed after reset release → state IDLE, strobes 0, `cpu_rdata`=0, no DONE cycle.
- With `DM_MISALIGN_TRAP_EN`: half load at addr=0x3 → no strobe, `dm_err`=1 for one cycle at cycle 1, stall low at cycle 1.
